uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Transmit byte buffer and start sequencer between the UART register interface and the UART core. Bytes pushed from the register side (TXDATA writes) are queued in a DEPTH-entry FIFO. A small FSM drains them one at a time into the core's start/data inputs. It paces each byte on the core's busy flag, so software no longer has to poll busy per byte.

## Interface
- DEPTH, 16, FIFO entries; power of two, ≥2; AW = log2(DEPTH) derived internally
- ACK_TO, 15, max cycles in WAIT_BUSY before start is re-issued; 1..255
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset; one clock, reset is synchronous and active-low (rst=0 resets on the next rising edge)
- i_en  in  1  UART enable; gates only the start of a new byte
- i_flush  in  1  synchronous FIFO clear
- i_push  in  1  enqueue request, one byte per asserted cycle
- i_push_data  in  8  byte to enqueue
- o_full  out  1  FIFO holds DEPTH entries
- o_empty  out  1  FIFO holds 0 entries
- o_level  out  AW+1  current entry count, 0..DEPTH
- o_ovf  out  1  one-cycle pulse: push dropped because FIFO full
- o_str_tx  out  1  one-cycle start pulse to UART core
- o_data_tx  out  8  byte presented to core; stable from pop until next pop
- i_busy_tx  in  1  core transmit busy
- o_idle  out  1  FIFO empty and FSM in IDLE

## Operation
- States: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If i_en & !o_empty & !i_busy_tx: pop the head into o_data_tx, go to START.
  - Otherwise stay.
- START: o_str_tx=1 for this cycle only; clear the timeout counter; go to WAIT_BUSY.
- WAIT_BUSY:
  - If i_busy_tx: go to WAIT_DONE.
  - Else increment the counter. When counter reaches ACK_TO, go to START to re-issue the same byte. It is not popped again.
- WAIT_DONE: when !i_busy_tx, go to IDLE.
- i_en deasserted mid-byte: the FSM completes the current byte, then holds in IDLE. The FIFO still accepts pushes.
- Push rules:
  - A push is accepted if !o_full, or if a pop occurs the same cycle.
  - Push while full with no pop: data dropped, o_ovf pulses, level unchanged.
- Pop occurs only from a non-empty FIFO, judged at the cycle start. There is no same-cycle push-to-pop bypass.
- Level update: o_level +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- Pointers wrap modulo DEPTH. o_full = (level==DEPTH), o_empty = (level==0).
- Flush:
  - Pointers and level go to 0 next cycle.
  - A push or pop in the same cycle is ignored, and o_ovf is not pulsed.
  - A byte already in o_data_tx and the FSM state are unaffected, so an in-flight byte completes.

## Timing
- Reset values: o_str_tx=0, o_data_tx=8'h00, o_ovf=0, o_level=0, o_empty=1, o_full=0, o_idle=1. FSM=IDLE, counter=0.
- All outputs are registered or decoded from registers only. No input-to-output combinational path.
- Latency: push at cycle N on an empty FIFO, FSM IDLE, core idle:
  - level=1 at N+1
  - pop and o_data_tx valid at N+2
  - o_str_tx high during N+3
- Minimum byte period: core busy duration + 3 cycles (IDLE, START, first WAIT_BUSY sample).
- Timeout case: with busy never rising, o_str_tx re-pulses every ACK_TO+2 cycles.
- Reset mid-byte: all state returns to reset values on the next edge. Queued bytes are lost.

## Structure
- Package uart_pkg holds:
  - FSM state encoding (2-bit localparams)
  - ACK_TO default
  - helper clog2 function
- Sub-module uart_sync_fifo: generic DEPTH×8 register-array FIFO providing push/pop/flush/level/full/empty/ovf.
- The FSM and o_data_tx register live in uart_tx_fifo.

## Test plan
- Single byte: push 8'hA5 with core model busy 10 cycles after start → o_str_tx one pulse at N+3 with o_data_tx=8'hA5; o_idle=1 after busy falls.
- Burst/full: with i_en=0, push 17 bytes 8'h00..8'h10 into DEPTH=16 → o_full=1, o_level=16, o_ovf pulses on the 17th. Then i_en=1 → exactly 8'h00..8'h0F transmitted in order.
- Simultaneous push/pop at full → level stays 16, no o_ovf, byte accepted and later transmitted in order.
- Flush mid-transfer: 4 bytes queued, flush while in WAIT_DONE → current byte finishes, no further starts, level=0, o_empty=1.
- Timeout: core ignores start (busy stuck 0) for ACK_TO=3 → o_str_tx re-pulses every 5 cycles with the same data; level decremented once only.
- Reset: rst=0 for one edge while in WAIT_DONE with 5 queued → all outputs at reset values next cycle, no further o_str_tx.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit buffer.
// FSM encoding, timeout default and a width helper.
package uart_pkg;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_START     = 2'd1;
  localparam logic [1:0] ST_WAIT_BUSY = 2'd2;
  localparam logic [1:0] ST_WAIT_DONE = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE      = ST_IDLE,
    S_START     = ST_START,
    S_WAIT_BUSY = ST_WAIT_BUSY,
    S_WAIT_DONE = ST_WAIT_DONE
  } tx_state_e;

  localparam int ACK_TO_DEF = 15;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Push-side and core-side signals of the UART transmit buffer.
// master drives pushes and core busy; slave is the buffer.
interface uart_tx_fifo_if
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) ();
  localparam int LW = clog2(DEPTH) + 1;

  logic          i_push;
  logic [7:0]    i_push_data;
  logic          o_full;
  logic          o_empty;
  logic [LW-1:0] o_level;
  logic          o_ovf;
  logic          o_str_tx;
  logic [7:0]    o_data_tx;
  logic          i_busy_tx;

  modport master (
    output i_push, i_push_data, i_busy_tx,
    input  o_full, o_empty, o_level, o_ovf,
    input  o_str_tx, o_data_tx
  );

  modport slave (
    input  i_push, i_push_data, i_busy_tx,
    output o_full, o_empty, o_level, o_ovf,
    output o_str_tx, o_data_tx
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// Generic DEPTH x 8 register-array FIFO.
// Flush wins over push/pop; full push without pop drops and flags.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush_i,
  input  logic                    push_i,
  input  logic [7:0]              data_i,
  input  logic                    pop_i,
  output logic [7:0]              data_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic [clog2(DEPTH):0]   level_o,
  output logic                    ovf_o
);
  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          ovf_q, ovf_d;
  logic          full, empty;
  logic          push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign pop_ok  = pop_i & ~empty & ~flush_i;
  assign push_ok = push_i & (~full | pop_ok) & ~flush_i;

  // Next pointers, level and overflow pulse
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = push_i & full & ~pop_ok & ~flush_i;
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      level_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + AW'(1);
      if (pop_ok)  rptr_d = rptr_q + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   level_d = level_q + LW'(1);
        2'b01:   level_d = level_q - LW'(1);
        default: level_d = level_q;
      endcase
    end
  end

  // Pointer, level and overflow registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage array; contents need no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= data_i;
  end

  assign data_o  = mem_q[rptr_q];
  assign full_o  = full;
  assign empty_o = empty;
  assign level_o = level_q;
  assign ovf_o   = ovf_q;
endmodule

// File: rtl/uart_tx_fifo.sv
// UART transmit buffer and start sequencer.
// Drains queued bytes into the core, paced on its busy flag.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ACK_TO = ACK_TO_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_en,
  input  logic           i_flush,
  output logic           o_idle,
  uart_tx_fifo_if.slave  bus
);
  tx_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] data_q, data_d;
  logic       str_q, str_d;
  logic       pop;
  logic [7:0] head;
  logic       empty;

  uart_sync_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (i_flush),
    .push_i  (bus.i_push),
    .data_i  (bus.i_push_data),
    .pop_i   (pop),
    .data_o  (head),
    .full_o  (bus.o_full),
    .empty_o (empty),
    .level_o (bus.o_level),
    .ovf_o   (bus.o_ovf)
  );

  // Sequencer next state; a flush cycle never starts a new byte
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    str_d   = 1'b0;
    pop     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (i_en & ~empty & ~bus.i_busy_tx & ~i_flush) begin
          pop     = 1'b1;
          data_d  = head;
          state_d = S_START;
        end
      end
      S_START: begin
        str_d   = 1'b1;
        cnt_d   = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (bus.i_busy_tx) begin
          state_d = S_WAIT_DONE;
        end else if (cnt_q == 8'(ACK_TO)) begin
          state_d = S_START;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.i_busy_tx) state_d = S_IDLE;
      end
    endcase
  end

  // Sequencer state, timeout counter and registered core outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      str_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      str_q   <= str_d;
    end
  end

  assign bus.o_str_tx  = str_q;
  assign bus.o_data_tx = data_q;
  assign bus.o_empty   = empty;
  assign o_idle        = empty & (state_q == S_IDLE);
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed pushes, core model, scoreboard.
// Expected bytes queue at push time; a monitor checks each start.
module tb_uart_tx_fifo;
  import uart_pkg::*;

  localparam int DEPTH = 16;
  localparam int ACKTO = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic i_en = 1'b0;
  logic i_flush = 1'b0;
  logic o_idle;

  uart_tx_fifo_if #(.DEPTH(DEPTH)) bus ();

  uart_tx_fifo #(.DEPTH(DEPTH), .ACK_TO(ACKTO)) dut (
    .clk     (clk),
    .rst     (rst),
    .i_en    (i_en),
    .i_flush (i_flush),
    .o_idle  (o_idle),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int pulse_t[$];
  int starts = 0;
  int cyc = 0;
  bit ack_en = 1'b1;
  int blen = 4;
  int bcnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_str"},   32'(bus.o_str_tx), 0);
    check({tag, "_data"},  32'(bus.o_data_tx), 0);
    check({tag, "_ovf"},   32'(bus.o_ovf), 0);
    check({tag, "_level"}, 32'(bus.o_level), 0);
    check({tag, "_empty"}, 32'(bus.o_empty), 1);
    check({tag, "_full"},  32'(bus.o_full), 0);
    check({tag, "_idle"},  32'(o_idle), 1);
  endtask

  task automatic wait_idle(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (o_idle && !bus.i_busy_tx) break;
    end
    check(name, 32'(o_idle && !bus.i_busy_tx), 1);
  endtask

  task automatic wait_busy(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (bus.i_busy_tx) break;
    end
    check(name, 32'(bus.i_busy_tx), 1);
  endtask

  // Core model: busy for blen cycles after an acknowledged start
  initial begin
    bus.i_busy_tx = 1'b0;
    forever begin
      @(negedge clk);
      if (bcnt > 0) bcnt--;
      if (bus.o_str_tx && ack_en) bcnt = blen;
      bus.i_busy_tx = (bcnt > 0);
    end
  end

  // Monitor: every start must carry the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (rst && bus.o_str_tx) begin
        starts++;
        pulse_t.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start actual=%0h required=none",
                   bus.o_data_tx);
        end else begin
          check("tx_data", 32'(bus.o_data_tx), 32'(exp_q[0]));
          if (ack_en) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    int s0;
    bus.i_push = 1'b0;
    bus.i_push_data = 8'h00;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    check_reset("rst");

    // single byte latency
    i_en = 1'b1;
    blen = 10;
    @(negedge clk);
    bus.i_push = 1'b1;
    bus.i_push_data = 8'hA5;
    exp_q.push_back(8'hA5);
    @(posedge clk); #1;
    check("t1_level_n1", 32'(bus.o_level), 1);
    @(negedge clk);
    bus.i_push = 1'b0;
    @(posedge clk); #1;
    check("t1_data_n2", 32'(bus.o_data_tx), 32'hA5);
    check("t1_str_n2", 32'(bus.o_str_tx), 0);
    @(posedge clk); #1;
    check("t1_str_n3", 32'(bus.o_str_tx), 1);
    @(posedge clk); #1;
    check("t1_str_n4", 32'(bus.o_str_tx), 0);
    wait_idle("t1_idle", 40);

    // burst to full with overflow
    i_en = 1'b0;
    blen = 4;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      bus.i_push = 1'b1;
      bus.i_push_data = 8'(k);
      if (k < 16) exp_q.push_back(8'(k));
      if (k == 16) check("t2_no_ovf_16th", 32'(bus.o_ovf), 0);
    end
    @(negedge clk);
    bus.i_push = 1'b0;
    check("t2_ovf", 32'(bus.o_ovf), 1);
    check("t2_full", 32'(bus.o_full), 1);
    check("t2_level", 32'(bus.o_level), 16);
    @(negedge clk);
    check("t2_ovf_pulse", 32'(bus.o_ovf), 0);
    check("t2_level_hold", 32'(bus.o_level), 16);

    // push and pop together while full
    @(negedge clk);
    i_en = 1'b1;
    bus.i_push = 1'b1;
    bus.i_push_data = 8'h40;
    exp_q.push_back(8'h40);
    @(negedge clk);
    bus.i_push = 1'b0;
    check("t3_level", 32'(bus.o_level), 16);
    check("t3_full", 32'(bus.o_full), 1);
    check("t3_no_ovf", 32'(bus.o_ovf), 0);
    wait_idle("t3_drain", 400);
    check("t3_sb_empty", 32'(exp_q.size()), 0);

    // flush during WAIT_DONE
    blen = 10;
    s0 = starts;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.i_push = 1'b1;
      bus.i_push_data = 8'(8'hB0 + k);
      if (k == 0) exp_q.push_back(8'hB0);
    end
    @(negedge clk);
    bus.i_push = 1'b0;
    wait_busy("t4_busy", 30);
    check("t4_level_pre", 32'(bus.o_level), 3);
    @(negedge clk);
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0;
    check("t4_level", 32'(bus.o_level), 0);
    check("t4_empty", 32'(bus.o_empty), 1);
    wait_idle("t4_idle", 40);
    check("t4_starts", 32'(starts - s0), 1);

    // timeout re-issue with busy stuck low
    ack_en = 1'b0;
    blen = 4;
    pulse_t.delete();
    @(negedge clk);
    bus.i_push = 1'b1;
    bus.i_push_data = 8'hC3;
    exp_q.push_back(8'hC3);
    @(negedge clk);
    bus.i_push = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (pulse_t.size() >= 3) break;
    end
    check("t5_pulses", 32'(pulse_t.size() >= 3), 1);
    if (pulse_t.size() >= 3) begin
      check("t5_period1", 32'(pulse_t[1] - pulse_t[0]), ACKTO + 2);
      check("t5_period2", 32'(pulse_t[2] - pulse_t[1]), ACKTO + 2);
    end
    check("t5_level", 32'(bus.o_level), 0);
    check("t5_empty", 32'(bus.o_empty), 1);
    ack_en = 1'b1;
    wait_idle("t5_idle", 40);
    check("t5_sb_empty", 32'(exp_q.size()), 0);

    // reset while in WAIT_DONE with bytes queued
    i_en = 1'b0;
    blen = 10;
    s0 = starts;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      bus.i_push = 1'b1;
      bus.i_push_data = 8'(8'hD0 + k);
      if (k == 0) exp_q.push_back(8'hD0);
    end
    @(negedge clk);
    bus.i_push = 1'b0;
    i_en = 1'b1;
    wait_busy("t6_busy", 30);
    check("t6_level_pre", 32'(bus.o_level), 5);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_reset("t6");
    repeat (20) @(negedge clk);
    check("t6_starts", 32'(starts - s0), 1);
    check("t6_sb_empty", 32'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
